// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with a small input FIFO,
// run-time bit period, parity and stop-bit count, LSB-first framing.
// Ports:
//   clk, reset          - system clock, synchronous active-high reset
//   cfg_div             - bit period = cfg_div+1 clk cycles
//   cfg_parity          - 00/11 none, 01 even, 10 odd
//   cfg_stop2           - 0 one stop bit, 1 two stop bits
//   s_valid/s_ready     - input stream handshake (s_ready = !full)
//   s_data              - payload word
//   uart_txd            - registered serial output, idle high
//   uart_tx_busy        - frame in progress or FIFO non-empty
//   fifo_level          - FIFO occupancy
module uart_tx_fifo #(
   parameter int PAYLOAD_BITS = 8,
   parameter int FIFO_DEPTH   = 4,
   parameter int DIV_WIDTH    = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [DIV_WIDTH-1:0]             cfg_div,
   input  logic [1:0]                       cfg_parity,
   input  logic                             cfg_stop2,
   input  logic                             s_valid,
   output logic                             s_ready,
   input  logic [PAYLOAD_BITS-1:0]          s_data,
   output logic                             uart_txd,
   output logic                             uart_tx_busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = $clog2(FIFO_DEPTH+1);
   localparam int BW = $clog2(PAYLOAD_BITS+1);
   localparam logic [BW-1:0] LAST_BIT = BW'(PAYLOAD_BITS-1);
   localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   logic [PAYLOAD_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]           wptr, rptr;
   logic [LW-1:0]           level;
   logic                    push, pop, empty;
   logic [PAYLOAD_BITS-1:0] head;

   state_t                  state, state_n;
   logic [DIV_WIDTH-1:0]    cyc, cyc_n, div_l;
   logic [BW-1:0]           bitc, bitc_n, stop_last;
   logic [PAYLOAD_BITS-1:0] shift, shift_n;
   logic [1:0]              par_l;
   logic                    stop2_l, par_x, par_en, par_bit;
   logic                    txd, txd_n, bit_end;

   // s_ready looks only at full: a same-cycle pop never frees a slot early
   assign s_ready      = (level != FULL_LVL);
   assign push         = s_valid && s_ready;
   assign empty        = (level == '0);
   assign head         = mem[rptr];
   assign fifo_level   = level;
   assign uart_txd     = txd;
   assign uart_tx_busy = (state != IDLE) || !empty;

   always_ff @(posedge clk) begin
      if (push)
         mem[wptr] <= s_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         level <= '0;
      end else begin
         if (push)
            wptr <= wptr + AW'(1);
         if (pop)
            rptr <= rptr + AW'(1);
         if (push && !pop)
            level <= level + LW'(1);
         else if (pop && !push)
            level <= level - LW'(1);
      end
   end

   // Frame settings are captured with the word so a config change
   // mid-frame only affects frames popped afterwards.
   assign par_en    = (par_l == 2'b01) || (par_l == 2'b10);
   assign par_bit   = par_x ^ (par_l == 2'b10);
   assign stop_last = BW'(stop2_l);
   assign bit_end   = (cyc == div_l);

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cyc     <= '0;
         bitc    <= '0;
         shift   <= '0;
         txd     <= 1'b1;
         div_l   <= '0;
         par_l   <= '0;
         stop2_l <= 1'b0;
         par_x   <= 1'b0;
      end else begin
         state <= state_n;
         cyc   <= cyc_n;
         bitc  <= bitc_n;
         shift <= shift_n;
         txd   <= txd_n;
         if (pop) begin
            div_l   <= cfg_div;
            par_l   <= cfg_parity;
            stop2_l <= cfg_stop2;
            par_x   <= ^head;
         end
      end
   end

   // txd_n is the level for the bit that starts at this edge, so the
   // output register changes only at bit boundaries.
   always_comb begin
      state_n = state;
      cyc_n   = cyc;
      bitc_n  = bitc;
      shift_n = shift;
      txd_n   = txd;
      pop     = 1'b0;
      unique case (state)
         IDLE: begin
            txd_n = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_n = head;
               cyc_n   = '0;
               txd_n   = 1'b0;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               cyc_n   = '0;
               bitc_n  = '0;
               txd_n   = shift[0];
               state_n = DATA;
            end else begin
               cyc_n = cyc + DIV_WIDTH'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               cyc_n = '0;
               if (bitc == LAST_BIT) begin
                  bitc_n = '0;
                  if (par_en) begin
                     txd_n   = par_bit;
                     state_n = PARITY;
                  end else begin
                     txd_n   = 1'b1;
                     state_n = STOP;
                  end
               end else begin
                  bitc_n  = bitc + BW'(1);
                  shift_n = shift >> 1;
                  txd_n   = shift[1];
               end
            end else begin
               cyc_n = cyc + DIV_WIDTH'(1);
            end
         end
         PARITY: begin
            if (bit_end) begin
               cyc_n   = '0;
               bitc_n  = '0;
               txd_n   = 1'b1;
               state_n = STOP;
            end else begin
               cyc_n = cyc + DIV_WIDTH'(1);
            end
         end
         STOP: begin
            if (bit_end) begin
               cyc_n = '0;
               if (bitc == stop_last) begin
                  bitc_n = '0;
                  // chain straight into the next start bit, no idle gap
                  if (!empty) begin
                     pop     = 1'b1;
                     shift_n = head;
                     txd_n   = 1'b0;
                     state_n = START;
                  end else begin
                     txd_n   = 1'b1;
                     state_n = IDLE;
                  end
               end else begin
                  bitc_n = bitc + BW'(1);
               end
            end else begin
               cyc_n = cyc + DIV_WIDTH'(1);
            end
         end
         default: begin
            txd_n   = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

endmodule
